// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage with a one-entry output register.
//
// This stage reads an asynchronous-read instruction ROM at the current fetch
// PC. It presents each instruction to a consumer through a valid/ready
// handshake. A redirect replaces the fetch PC and flushes the held word,
// which costs one bubble. A redirect to an address that is not word aligned
// is forced onto the word boundary and sets a sticky misalign flag.
//
// Parameters
//   ANCHO     instruction word width in bits
//   LARGO     number of ROM words (rom_addr is $clog2(LARGO) bits wide)
//   RESET_PC  byte address fetched first after reset
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous active-high reset
//   rom_addr        word address to the ROM (fetch_pc[AW+1:2])
//   rom_dout        ROM data for rom_addr, valid in the same cycle
//   redirect_valid  redirect the fetch stream to redirect_pc
//   redirect_pc     redirect byte address
//   out_valid       out_instr/out_pc hold a valid instruction
//   out_ready       consumer accepts the instruction this cycle
//   out_instr       fetched instruction
//   out_pc          byte address of out_instr
//   misalign        sticky: a redirect had redirect_pc[1:0] != 0
//   cnt_fetch       number of completed output handshakes
//
// Configuration
//   IFETCH_PERF_EN  when defined, cnt_fetch counts completed handshakes and
//                   wraps at 2^32. When undefined, no counter is built and
//                   cnt_fetch is tied to 0.
// ---------------------------------------------------------------------------
module ifetch #(
    parameter int          ANCHO    = 32,
    parameter int          LARGO    = 1024,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [$clog2(LARGO)-1:0] rom_addr,
    input  logic [ANCHO-1:0]         rom_dout,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ANCHO-1:0]         out_instr,
    output logic [31:0]              out_pc,
    output logic                     misalign,
    output logic [31:0]              cnt_fetch
);

    localparam int AW = $clog2(LARGO);

    logic [31:0]      fetch_pc_q,  fetch_pc_d;
    logic             out_valid_q, out_valid_d;
    logic [ANCHO-1:0] out_instr_q, out_instr_d;
    logic [31:0]      out_pc_q,    out_pc_d;
    logic             misalign_q,  misalign_d;
    logic             load;

    // Truncating the byte PC gives the modulo-LARGO ROM wrap for free.
    assign rom_addr = fetch_pc_q[AW+1:2];

    // The output register may take a new word when it is empty or is being
    // drained this cycle.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        misalign_d  = misalign_q | (redirect_valid & (|redirect_pc[1:0]));

        if (redirect_valid) begin
            // A redirect wins over a load. The word read this cycle belongs
            // to the old stream, so it is dropped. A word handed over in
            // this same cycle still counts as consumed.
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (load) begin
            out_instr_d = rom_dout;
            out_pc_d    = fetch_pc_q;
            out_valid_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= 32'h0;
            misalign_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] cnt_q, cnt_d;
    logic        handshake;

    assign handshake = out_valid_q && out_ready;

    always_comb begin
        cnt_d = cnt_q + {31'b0, handshake};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_fetch = cnt_q;
`else
    assign cnt_fetch = 32'h0;
`endif

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- directed bench for ifetch.
// Configuration: LARGO=16, RESET_PC=0. ROM word i holds 32'h100 + i.
// Outputs are sampled 1 ns after the rising edge. Inputs change at that
// same point.
// ---------------------------------------------------------------------------
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign;
    logic [31:0] cnt_fetch;

    int checks;
    int failures;

    ifetch #(
        .ANCHO    (32),
        .LARGO    (16),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign       (misalign),
        .cnt_fetch      (cnt_fetch)
    );

    // Asynchronous ROM model: word i = 0x100 + i
    assign rom_dout = 32'h100 + {28'h0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b expected=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h expected=0", out_instr); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign actual=%0b expected=0", misalign); end
        checks++; if (cnt_fetch !== 32'h0) begin failures++; $display("FAIL reset_cnt actual=%0d expected=0", cnt_fetch); end
        checks++; if (rom_addr !== 4'd0) begin failures++; $display("FAIL reset_rom_addr actual=%0d expected=0", rom_addr); end
    endtask

    task automatic test_stream();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] actual=%0b expected=1", i, out_valid); end
            checks++; if (out_pc !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] actual=%h expected=%h", i, out_pc, 32'(4 * i)); end
            checks++; if (out_instr !== 32'(32'h100 + i)) begin failures++; $display("FAIL stream_instr[%0d] actual=%h expected=%h", i, out_instr, 32'(32'h100 + i)); end
        end
    endtask

    task automatic test_stall();
        // The bench is presenting pc 0x8 now. Hold it for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h102)
                begin failures++; $display("FAIL stall_hold[%0d] actual v=%0b pc=%h instr=%h expected v=1 pc=8 instr=102", i, out_valid, out_pc, out_instr); end
            checks++; if (rom_addr !== 4'd3) begin failures++; $display("FAIL stall_rom_addr[%0d] actual=%0d expected=3", i, rom_addr); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'hC || out_instr !== 32'h103)
            begin failures++; $display("FAIL stall_resume actual pc=%h instr=%h expected pc=c instr=103", out_pc, out_instr); end
    endtask

    task automatic test_redirect();
        // Cycle N: the consumer takes pc 0xC while the redirect happens.
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redirect_bubble actual=%0b expected=0", out_valid); end
        checks++; if (rom_addr !== 4'd8) begin failures++; $display("FAIL redirect_rom_addr actual=%0d expected=8", rom_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h108)
            begin failures++; $display("FAIL redirect_first actual v=%0b pc=%h instr=%h expected v=1 pc=20 instr=108", out_valid, out_pc, out_instr); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL redirect_misalign actual=%0b expected=0", misalign); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'h38;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_pc !== 32'h38 || out_instr !== 32'h10E)
            begin failures++; $display("FAIL wrap_start actual pc=%h instr=%h expected pc=38 instr=10e", out_pc, out_instr); end
        checks++; if (rom_addr !== 4'd15) begin failures++; $display("FAIL wrap_addr15 actual=%0d expected=15", rom_addr); end
        tick();
        checks++; if (out_pc !== 32'h3C || out_instr !== 32'h10F)
            begin failures++; $display("FAIL wrap_last actual pc=%h instr=%h expected pc=3c instr=10f", out_pc, out_instr); end
        checks++; if (rom_addr !== 4'd0) begin failures++; $display("FAIL wrap_addr0 actual=%0d expected=0", rom_addr); end
        tick();
        checks++; if (out_pc !== 32'h40 || out_instr !== 32'h100)
            begin failures++; $display("FAIL wrap_over actual pc=%h instr=%h expected pc=40 instr=100", out_pc, out_instr); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_set actual=%0b expected=1", misalign); end
        tick();
        checks++; if (out_pc !== 32'h20 || out_instr !== 32'h108)
            begin failures++; $display("FAIL misalign_fetch actual pc=%h instr=%h expected pc=20 instr=108", out_pc, out_instr); end
        tick(); tick();
        checks++; if (misalign !== 1'b1 || out_pc !== 32'h28)
            begin failures++; $display("FAIL misalign_sticky actual m=%0b pc=%h expected m=1 pc=28", misalign, out_pc); end
    endtask

    task automatic test_rst_redirect();
        logic [31:0] exp_cnt;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || misalign !== 1'b0 || cnt_fetch !== 32'h0 || rom_addr !== 4'd0)
            begin failures++; $display("FAIL rstredir_state actual v=%0b m=%0b cnt=%0d addr=%0d expected 0 0 0 0", out_valid, misalign, cnt_fetch, rom_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100)
            begin failures++; $display("FAIL rstredir_first actual v=%0b pc=%h instr=%h expected v=1 pc=0 instr=100", out_valid, out_pc, out_instr); end
        for (int i = 0; i < 10; i++) tick();
`ifdef IFETCH_PERF_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (cnt_fetch !== exp_cnt) begin failures++; $display("FAIL cnt_after_10 actual=%0d expected=%0d", cnt_fetch, exp_cnt); end
        checks++; if (out_pc !== 32'h28 || out_instr !== 32'h10A)
            begin failures++; $display("FAIL back_to_back_pc actual pc=%h instr=%h expected pc=28 instr=10a", out_pc, out_instr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_misalign();
        test_rst_redirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL expose parameter ANCHO, default 32, instruction word width in bits.
REQ-002 SHALL expose parameter LARGO, default 1024, number of instruction ROM words.
REQ-003 SHALL expose parameter RESET_PC, default 32'h0, byte address fetched first after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rom_addr  output  $clog2(LARGO)  word address to asynchronous-read instruction ROM.
REQ-007 SHALL have port rom_dout  input  ANCHO  ROM data for rom_addr, valid in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  redirect fetch stream (branch/jump).
REQ-009 SHALL have port redirect_pc  input  32  redirect byte address.
REQ-010 SHALL have port out_valid  output  1  out_instr/out_pc hold a valid instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the instruction this cycle.
REQ-012 SHALL have port out_instr  output  ANCHO  fetched instruction.
REQ-013 SHALL have port out_pc  output  32  byte address of out_instr.
REQ-014 SHALL have port misalign  output  1  sticky flag: a redirect had redirect_pc[1:0]!=0.
REQ-015 SHALL have port cnt_fetch  output  32  count of completed out handshakes (see Configuration).

Function
REQ-016 SHALL hold a 32-bit fetch_pc; rom_addr SHALL equal fetch_pc[$clog2(LARGO)+1:2] combinationally.
REQ-017 Load condition: load = !out_valid || out_ready.
REQ-018 On load without redirect: out_instr<=rom_dout, out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+4.
REQ-019 Without load: out_valid, out_instr, out_pc and fetch_pc SHALL hold unchanged.
REQ-020 Handshake completes when out_valid && out_ready in the same cycle.
REQ-021 Redirect (cycle N) SHALL override load: fetch_pc<={redirect_pc[31:2],2'b00}, out_valid<=0 (flush).
REQ-022 After redirect in cycle N, first instruction from the new PC SHALL be presented with out_valid=1 in cycle N+2 (one bubble).
REQ-023 Handshake coinciding with redirect SHALL count as consumed; the flushed next word is never presented.
REQ-024 redirect_pc[1:0]!=0 with redirect_valid SHALL set misalign=1; it stays 1 until rst.
REQ-025 fetch_pc SHALL increment modulo 2^32; rom_addr wraps modulo LARGO by truncation, no error.
REQ-026 Steady state with out_ready=1: one instruction per cycle, zero bubbles.
REQ-027 out_instr/out_pc SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst=1 at a clock edge: fetch_pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, misalign<=0, cnt_fetch<=0.
REQ-029 rst SHALL take priority over redirect_valid and load in the same cycle.
REQ-030 First out_valid=1 SHALL occur in the first cycle after rst deasserts, out_pc=RESET_PC.
REQ-031 rst mid-stream SHALL discard any held instruction; no handshake completes in a rst cycle.

Configuration
REQ-032 Macro IFETCH_PERF_EN defined: cnt_fetch increments by 1 per completed handshake, wraps at 2^32.
REQ-033 IFETCH_PERF_EN undefined: counter not built, cnt_fetch tied to 0; all other behaviour identical.

Verification (LARGO=16, ROM word i = 32'h100+i, RESET_PC=0)
REQ-034 Release rst, out_ready=1 -> out_valid=1 next cycle; out_pc 0,4,8,...; out_instr 0x100,0x101,0x102, one per cycle.
REQ-035 out_ready=0 for 3 cycles with out_pc=0x8 -> out_instr=0x102, out_pc=0x8 held; rom_addr stays 3; resumes 0xC next.
REQ-036 redirect_valid=1, redirect_pc=0x20 in cycle N -> out_valid=0 at N+1; N+2 out_pc=0x20, out_instr=0x108.
REQ-037 Streaming past 0x3C -> rom_addr 15 then 0; out_pc=0x40 with out_instr=0x100.
REQ-038 Redirect to 0x22 -> fetch at 0x20 (out_instr=0x108), misalign=1 held until next rst.
REQ-039 rst and redirect asserted together -> out_valid=0, next out_pc=0; cnt_fetch=0 (IFETCH_PERF_EN) then counts 10 after 10 handshakes.
